alu_seq_ctrl: RTL and testbench

Parametrised control sequencer that drives the single-bus datapath through instruction fetch (T0–T2) and execution (T3–T5) of register-register and immediate ALU instructions. It replaces hand-sequenced bench stimulus with a synthesizable FSM. It adds:

- decode of two instruction classes;
- a memory-ready wait-state handshake with timeout;
- fault reporting;
- back-to-back execution;
- a retired-instruction counter.

---
 rtl/alu_seq_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - fetch/execute control sequencer for the single-bus ALU datapath
module alu_seq_ctrl #(
    parameter int OPW       = 5,
    parameter int ALUW      = 5,
    parameter int REG_CNT   = 12,
    parameter int IMM_BASE  = 16,
    parameter int IMM_CNT   = 8,
    parameter int MAX_WAIT  = 15,
    parameter int CNT_W     = 16,
    parameter int FETCH_INC = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic [31:0]      ir,
    input  logic             mem_rdy,
    output logic             Pout,
    output logic             MARen,
    output logic             IncPC,
    output logic             Read,
    output logic             MDRen,
    output logic             MDROut,
    output logic             IRen,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rout,
    output logic             Rin,
    output logic             Yen,
    output logic             Cout,
    output logic             Zen,
    output logic             ZLOout,
    output logic [ALUW-1:0]  alu_control,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WW-1:0]  WAIT_LAST = WW'(MAX_WAIT - 1);
    localparam logic [OPW:0]   REG_END   = (OPW + 1)'(REG_CNT);
    localparam logic [OPW:0]   IMM_LO    = (OPW + 1)'(IMM_BASE);
    localparam logic [OPW:0]   IMM_END   = (OPW + 1)'(IMM_BASE + IMM_CNT);
    localparam logic [OPW-1:0] IMM_OFF   = OPW'(IMM_BASE);

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_FAULT
    } state_t;

    state_t           state_q;
    logic [WW-1:0]    wait_q;
    logic [OPW-1:0]   opcode_q;
    logic             imm_q;
    logic [CNT_W-1:0] instr_cnt_q;
    logic [1:0]       fault_code_q;

    logic [OPW-1:0] ir_op;
    logic [OPW:0]   op_ext;
    logic           is_reg;
    logic           is_imm;
    logic [OPW-1:0] alu_sel;
    logic           unused_ir;

    assign ir_op     = ir[31:32-OPW];
    assign op_ext    = {1'b0, ir_op};
    assign is_reg    = op_ext < REG_END;
    assign is_imm    = (op_ext >= IMM_LO) && (op_ext < IMM_END);
    assign alu_sel   = imm_q ? (opcode_q - IMM_OFF) : opcode_q;
    assign unused_ir = ^ir[31-OPW:0];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q      <= S_IDLE;
            wait_q       <= '0;
            opcode_q     <= '0;
            imm_q        <= 1'b0;
            instr_cnt_q  <= '0;
            fault_code_q <= 2'd0;
        end else begin
            case (state_q)
                S_IDLE: if (run) state_q <= S_T0;
                S_T0: begin
                    wait_q  <= '0;
                    state_q <= S_T1;
                end
                // mem_rdy takes priority over an expiring wait count
                S_T1: begin
                    if (mem_rdy) begin
                        state_q <= S_T2;
                    end else if (wait_q == WAIT_LAST) begin
                        state_q      <= S_FAULT;
                        fault_code_q <= 2'd2;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_T2: state_q <= S_T3;
                S_T3: begin
                    opcode_q <= ir_op;
                    imm_q    <= is_imm;
                    if (is_reg || is_imm) begin
                        state_q <= S_T4;
                    end else begin
                        state_q      <= S_FAULT;
                        fault_code_q <= 2'd1;
                    end
                end
                S_T4: state_q <= S_T5;
                S_T5: begin
                    instr_cnt_q <= instr_cnt_q + 1'b1;
                    state_q     <= run ? S_T0 : S_IDLE;
                end
                S_FAULT: begin
                    if (!run) begin
                        state_q      <= S_IDLE;
                        fault_code_q <= 2'd0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        Pout        = 1'b0;
        MARen       = 1'b0;
        IncPC       = 1'b0;
        Read        = 1'b0;
        MDRen       = 1'b0;
        MDROut      = 1'b0;
        IRen        = 1'b0;
        Gra         = 1'b0;
        Grb         = 1'b0;
        Grc         = 1'b0;
        Rout        = 1'b0;
        Rin         = 1'b0;
        Yen         = 1'b0;
        Cout        = 1'b0;
        Zen         = 1'b0;
        ZLOout      = 1'b0;
        alu_control = '0;
        done        = 1'b0;
        case (state_q)
            S_T0: begin
                Pout  = 1'b1;
                MARen = 1'b1;
                IncPC = (FETCH_INC != 0);
            end
            S_T1: begin
                Read  = 1'b1;
                MDRen = 1'b1;
            end
            S_T2: begin
                MDROut = 1'b1;
                IRen   = 1'b1;
            end
            S_T3: begin
                Grb  = 1'b1;
                Rout = 1'b1;
                Yen  = 1'b1;
            end
            S_T4: begin
                Zen         = 1'b1;
                alu_control = ALUW'(alu_sel);
                Cout        = imm_q;
                Grc         = !imm_q;
                Rout        = !imm_q;
            end
            S_T5: begin
                ZLOout = 1'b1;
                Gra    = 1'b1;
                Rin    = 1'b1;
                done   = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy       = (state_q != S_IDLE) && (state_q != S_FAULT);
    assign fault      = (state_q == S_FAULT);
    assign fault_code = fault_code_q;
    assign instr_cnt  = instr_cnt_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed bench for alu_seq_ctrl
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        run;
    logic [31:0] ir;
    logic        mem_rdy;
    logic Pout, MARen, IncPC, Read, MDRen, MDROut, IRen, Gra, Grb, Grc;
    logic Rout, Rin, Yen, Cout, Zen, ZLOout;
    logic [4:0]  alu_control;
    logic        busy, done, fault;
    logic [1:0]  fault_code;
    logic [15:0] instr_cnt;
    logic [15:0] strb;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [15:0] ST_IDLE = 16'h0000;
    localparam logic [15:0] ST_T0   = 16'hE000;
    localparam logic [15:0] ST_T1   = 16'h1800;
    localparam logic [15:0] ST_T2   = 16'h0600;
    localparam logic [15:0] ST_T3   = 16'h00A8;
    localparam logic [15:0] ST_T4I  = 16'h0006;
    localparam logic [15:0] ST_T4R  = 16'h0062;
    localparam logic [15:0] ST_T5   = 16'h0111;

    always #5 clk = ~clk;

    alu_seq_ctrl dut (
        .clk(clk), .clr(clr), .run(run), .ir(ir), .mem_rdy(mem_rdy),
        .Pout(Pout), .MARen(MARen), .IncPC(IncPC), .Read(Read), .MDRen(MDRen),
        .MDROut(MDROut), .IRen(IRen), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rout(Rout), .Rin(Rin), .Yen(Yen), .Cout(Cout), .Zen(Zen), .ZLOout(ZLOout),
        .alu_control(alu_control), .busy(busy), .done(done), .fault(fault),
        .fault_code(fault_code), .instr_cnt(instr_cnt)
    );

    assign strb = {Pout, MARen, IncPC, Read, MDRen, MDROut, IRen, Gra,
                   Grb, Grc, Rout, Rin, Yen, Cout, Zen, ZLOout};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b0; run = 1'b0; mem_rdy = 1'b1; ir = 32'd0;
        #3;
        chk("rst_strb", 32'(strb), 32'(ST_IDLE));
        chk("rst_cnt", 32'(instr_cnt), 0);
        chk("rst_busy", 32'({busy, done, fault, fault_code}), 0);
        #4;
        clr = 1'b1;

        // andi: opcode 19, single instruction
        ir = {5'd19, 27'd0}; run = 1'b1;
        tick(); chk("andi_t0", 32'(strb), 32'(ST_T0)); chk("andi_busy", 32'(busy), 1);
        run = 1'b0;
        tick(); chk("andi_t1", 32'(strb), 32'(ST_T1));
        tick(); chk("andi_t2", 32'(strb), 32'(ST_T2));
        tick(); chk("andi_t3", 32'(strb), 32'(ST_T3)); chk("andi_alu_t3", 32'(alu_control), 0);
        tick(); chk("andi_t4", 32'(strb), 32'(ST_T4I)); chk("andi_alu_t4", 32'(alu_control), 3);
        tick(); chk("andi_t5", 32'(strb), 32'(ST_T5)); chk("andi_done", 32'(done), 1);
        chk("andi_alu_t5", 32'(alu_control), 0);
        tick(); chk("andi_idle", 32'(strb), 32'(ST_IDLE)); chk("andi_cnt", 32'(instr_cnt), 1);
        chk("andi_idle_flags", 32'({busy, done}), 0);

        // register add, two back-to-back
        ir = 32'd0; run = 1'b1;
        tick(); chk("add_t0", 32'(strb), 32'(ST_T0));
        tick(); tick(); tick();
        tick(); chk("add_t4", 32'(strb), 32'(ST_T4R)); chk("add_alu", 32'(alu_control), 0);
        tick(); chk("add_t5", 32'(strb), 32'(ST_T5));
        tick(); chk("add_b2b_t0", 32'(strb), 32'(ST_T0)); chk("add_cnt1", 32'(instr_cnt), 2);
        run = 1'b0;
        tick(); tick(); tick(); tick();
        tick(); chk("add2_t5", 32'(done), 1);
        tick(); chk("add_idle", 32'(strb), 32'(ST_IDLE)); chk("add_cnt2", 32'(instr_cnt), 3);

        // three wait states in T1; done lands in cycle 9
        ir = {5'd23, 27'd0}; run = 1'b1;
        tick(); chk("ws_t0", 32'(strb), 32'(ST_T0));
        run = 1'b0; mem_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(); chk($sformatf("ws_t1_%0d", k), 32'(strb), 32'(ST_T1));
            if (k == 3) mem_rdy = 1'b1;
        end
        tick(); chk("ws_t2", 32'(strb), 32'(ST_T2));
        tick(); tick(); chk("ws_alu_imm_last", 32'(alu_control), 7);
        tick(); chk("ws_done_c9", 32'(done), 1);
        tick(); chk("ws_cnt", 32'(instr_cnt), 4);

        // mem_rdy rises in the last allowed T1 cycle: no fault
        run = 1'b1;
        tick();
        run = 1'b0; mem_rdy = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        chk("edge_t1_15", 32'(strb), 32'(ST_T1));
        mem_rdy = 1'b1;
        tick(); chk("edge_t2", 32'(strb), 32'(ST_T2)); chk("edge_nofault", 32'(fault), 0);
        tick(); tick(); tick(); tick();
        chk("edge_cnt", 32'(instr_cnt), 5);

        // memory timeout
        run = 1'b1;
        tick();
        mem_rdy = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        chk("to_t1_last", 32'(strb), 32'(ST_T1)); chk("to_pre_fault", 32'(fault), 0);
        tick(); chk("to_fault", 32'({fault, fault_code}), 32'({1'b1, 2'd2}));
        chk("to_strb", 32'(strb), 32'(ST_IDLE)); chk("to_busy", 32'(busy), 0);
        tick(); chk("to_hold", 32'({fault, fault_code}), 32'({1'b1, 2'd2}));
        run = 1'b0; mem_rdy = 1'b1;
        tick(); chk("to_clear", 32'({fault, fault_code}), 0);

        // illegal opcode 31
        ir = {5'd31, 27'd0}; run = 1'b1;
        tick(); tick(); tick();
        tick(); chk("ill_t3", 32'(strb), 32'(ST_T3));
        tick(); chk("ill_fault", 32'({fault, fault_code}), 32'({1'b1, 2'd1}));
        chk("ill_no_exec", 32'({Zen, Rin, done}), 0);
        run = 1'b0;
        tick(); chk("ill_clear", 32'(fault_code), 0);

        // opcode 12 sits between the classes
        ir = {5'd12, 27'd0}; run = 1'b1;
        tick(); tick(); tick(); tick();
        run = 1'b0;
        tick(); chk("gap_fault", 32'(fault_code), 1);
        tick(); chk("gap_cnt", 32'(instr_cnt), 5);

        // asynchronous clear during T4
        ir = {5'd19, 27'd0}; run = 1'b1;
        tick(); tick(); tick(); tick();
        tick(); chk("clr_pre_t4", 32'(strb), 32'(ST_T4I));
        #2 clr = 1'b0;
        #1;
        chk("clr_strb", 32'(strb), 0);
        chk("clr_outs", 32'({alu_control, busy, done, fault, fault_code}), 0);
        chk("clr_cnt", 32'(instr_cnt), 0);
        #2 clr = 1'b1;
        tick(); chk("clr_t0", 32'(strb), 32'(ST_T0)); chk("clr_t0_cnt", 32'(instr_cnt), 0);
        run = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        tick(); chk("clr_final_cnt", 32'(instr_cnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
